// File: rtl/unary_ops_pipe.sv
// -----------------------------------------------------------------------------
// unary_ops_pipe
//
// Two-stage valid/ready pipeline that applies a run-time-selected unary or
// reduction operator to a WIDTH-bit operand. It also keeps a saturating count
// of the results the consumer has taken.
//
//   S1: operand/opcode register. It loads whenever the producer transfers.
//   S2: result register. It drives out_data/out_err/out_valid.
//
// Optional feature macro: UNARY_OPS_PIPE_WILDEQ_EN
//   When defined, opcodes 10/11 perform a wildcard equality test against
//   in_pat under the in_care mask, and S1 also stores pat/care.
//   When undefined, opcodes 10/11 are illegal and S1 has no pat/care storage.
//
// Parameters:
//   WIDTH  operand/result width (1..64)
//   CNT_W  completed-operation counter width (1..32)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand/op offered          in_ready  block accepts this cycle
//   in_data    operand                     in_op     operator code
//   in_pat     wildcard pattern            in_care   wildcard care mask
//   out_valid  result available            out_ready consumer accepts
//   out_data   result (1-bit ops in bit 0) out_err   illegal opcode flag
//   op_count   saturating count of out_valid && out_ready transfers
// -----------------------------------------------------------------------------
module unary_ops_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_pat,
  input  logic [WIDTH-1:0] in_care,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [3:0] {
    OP_INV   = 4'd0,
    OP_POS   = 4'd1,
    OP_NEG   = 4'd2,
    OP_LNOT  = 4'd3,
    OP_RAND  = 4'd4,
    OP_RNAND = 4'd5,
    OP_ROR   = 4'd6,
    OP_RNOR  = 4'd7,
    OP_RXOR  = 4'd8,
    OP_RXNOR = 4'd9,
    OP_WEQ   = 4'd10,
    OP_WNEQ  = 4'd11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  op_e              s1_op;
  logic             adv1;
  logic             accept;
  logic [WIDTH-1:0] result;
  logic             result_err;

`ifdef UNARY_OPS_PIPE_WILDEQ_EN
  logic [WIDTH-1:0] s1_pat;
  logic [WIDTH-1:0] s1_care;
  logic             wild_match;
`else
  // Pattern inputs have no function in this build.
  logic             unused_wild;
  assign unused_wild = ^{in_pat, in_care};
`endif

  // S2 can take a new value when it is empty or is being drained this cycle.
  assign adv1     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv1;
  assign accept   = in_valid && in_ready;

  // Stage-1 occupancy. A simultaneous accept and S1->S2 move keeps S1 full,
  // so a stream flows with no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the payload registers carry no reset. They are only observed
  // when qualified by s1_valid, so resetting them would add reset fan-out
  // without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= in_data;
      s1_op   <= op_e'(in_op);
`ifdef UNARY_OPS_PIPE_WILDEQ_EN
      s1_pat  <= in_pat;
      s1_care <= in_care;
`endif
    end
  end

`ifdef UNARY_OPS_PIPE_WILDEQ_EN
  // A bit matches when it equals the pattern or is marked don't-care.
  assign wild_match = &(~(s1_data ^ s1_pat) | ~s1_care);
`endif

  // NOTE: every output of this block is given a default first. Any opcode
  // path that forgets an assignment then falls back to zero instead of
  // inferring a latch.
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (s1_op)
      OP_INV:   result    = ~s1_data;
      OP_POS:   result    = s1_data;
      OP_NEG:   result    = '0 - s1_data;
      OP_LNOT:  result[0] = ~|s1_data;
      OP_RAND:  result[0] = &s1_data;
      OP_RNAND: result[0] = ~&s1_data;
      OP_ROR:   result[0] = |s1_data;
      OP_RNOR:  result[0] = ~|s1_data;
      OP_RXOR:  result[0] = ^s1_data;
      OP_RXNOR: result[0] = ~^s1_data;
`ifdef UNARY_OPS_PIPE_WILDEQ_EN
      OP_WEQ:   result[0] = wild_match;
      OP_WNEQ:  result[0] = ~wild_match;
`endif
      default:  result_err = 1'b1;
    endcase
  end

  // Stage 2: the result register. It holds all outputs while stalled.
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (adv1) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result;
        out_err  <= result_err;
      end
    end
  end

  // The completed-output counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != CNT_MAX)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_unary_ops_pipe.sv
// -----------------------------------------------------------------------------
// tb_unary_ops_pipe
//
// Self-checking bench for unary_ops_pipe (WIDTH=8, CNT_W=16). A second
// instance with CNT_W=2 receives identical stimulus and exercises counter
// saturation. Expected results come from an arithmetic reference model and
// an in-order scoreboard of accepted items.
// -----------------------------------------------------------------------------
module tb_unary_ops_pipe;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_op;
  logic [W-1:0]  in_pat;
  logic [W-1:0]  in_care;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] op_count;

  logic          unused_sat_rdy;
  logic          unused_sat_valid;
  logic [W-1:0]  unused_sat_data;
  logic          unused_sat_err;
  logic [1:0]    sat_count;

  unary_ops_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_pat(in_pat), .in_care(in_care),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .op_count(op_count)
  );

  unary_ops_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(unused_sat_rdy), .in_data(in_data),
    .in_op(in_op), .in_pat(in_pat), .in_care(in_care),
    .out_valid(unused_sat_valid), .out_ready(out_ready), .out_data(unused_sat_data),
    .out_err(unused_sat_err), .op_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           acc_cyc;
  } exp_t;

  exp_t         q[$];
  int           checks  = 0;
  int           errors  = 0;
  int           cyc     = 0;
  int           exp_cnt = 0;
  bit           lat_chk = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_err;

  // Reference model, computed with plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] d, input logic [3:0] op,
                                 input logic [W-1:0] p, input logic [W-1:0] c);
    exp_t e;
    int   v;
    int   ones;
    v    = int'(d);
    ones = $countones(d);
    e.data = '0;
    e.err = 1'b0;
    e.acc_cyc = 0;
    case (op)
      4'd0: e.data = W'((1 << W) - 1 - v);
      4'd1: e.data = d;
      4'd2: e.data = W'(((1 << W) - v) % (1 << W));
      4'd3: e.data = W'(v == 0);
      4'd4: e.data = W'(ones == W);
      4'd5: e.data = W'(ones != W);
      4'd6: e.data = W'(v != 0);
      4'd7: e.data = W'(v == 0);
      4'd8: e.data = W'((ones % 2) == 1);
      4'd9: e.data = W'((ones % 2) == 0);
`ifdef UNARY_OPS_PIPE_WILDEQ_EN
      4'd10: e.data = W'($countones((d ^ p) & c) == 0);
      4'd11: e.data = W'($countones((d ^ p) & c) != 0);
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One clock cycle. It is entered just after a falling edge and returns at
  // the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [3:0] op,
                       input logic [W-1:0] p, input logic [W-1:0] c,
                       input logic ordy, output logic acc);
    logic drn;
    logic exp_rdy;
    int   exp_sat;
    exp_t e;
    checks++;
    if (op_count !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL op_count: got %0d expected %0d (cycle %0d)", op_count, exp_cnt, cyc);
    end
    exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
    checks++;
    if (sat_count !== 2'(exp_sat)) begin
      errors++;
      $display("FAIL sat_count: got %0d expected %0d (cycle %0d)", sat_count, exp_sat, cyc);
    end
    if (prev_stall) begin
      checks++;
      if ({out_valid, out_err, out_data} !== {1'b1, prev_err, prev_data}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
                 out_valid, out_err, out_data, prev_err, prev_data);
      end
    end
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    in_pat    = p;
    in_care   = c;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b (cycle %0d, in flight %0d)",
               in_ready, exp_rdy, cyc, q.size());
    end
    drn = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (drn) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: out_valid=1 data=%h with nothing in flight (cycle %0d)",
                 out_data, cyc);
      end else begin
        e = q.pop_front();
        if ((out_data !== e.data) || (out_err !== e.err)) begin
          errors++;
          $display("FAIL result: got data=%h err=%b expected data=%h err=%b (cycle %0d)",
                   out_data, out_err, e.data, e.err, cyc);
        end
        if (lat_chk) begin
          checks++;
          if (cyc - e.acc_cyc != 2) begin
            errors++;
            $display("FAIL latency: got %0d expected 2 cycles", cyc - e.acc_cyc);
          end
        end
        exp_cnt++;
      end
    end
    if (acc) begin
      e = model(d, op, p, c);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_err   = out_err;
    @(negedge clk);
    cyc++;
  endtask

  task automatic flush();
    logic acc;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle(1'b0, '0, 4'd0, '0, '0, 1'b1, acc);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL flush_timeout: got %0d items still pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_pat    = '0;
    in_care   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_err, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h expected all 0", out_valid, out_err, out_data);
    end
    checks++;
    if (op_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", op_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ds [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF,
                              8'h07, 8'h07, 8'h00, 8'h00};
    logic [3:0]   os [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd4, 4'd5,
                              4'd8, 4'd9, 4'd6, 4'd7};
    logic acc;
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, ds[i], os[i], '0, '0, 1'b1, acc);
    flush();
    checks++;
    if (op_count !== CW'(4)) begin
      errors++;
      $display("FAIL first_stream_count: got %0d expected 4", op_count);
    end
    for (int i = 4; i < 11; i++) cycle(1'b1, ds[i], os[i], '0, '0, 1'b1, acc);
    flush();
  endtask

  task automatic test_random();
    logic acc;
    lat_chk = 1'b1;
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 3) != 0), W'($urandom), 4'($urandom_range(0, 15)),
            W'($urandom), W'($urandom), 1'b1, acc);
    flush();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ds [3];
    logic [3:0]   os [3];
    int k = 0;
    logic acc;
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ds[i] = W'($urandom);
      os[i] = 4'($urandom_range(0, 9));
    end
    for (int i = 0; i < 5; i++) begin
      cycle((k < 3), ds[k % 3], os[k % 3], '0, '0, 1'b0, acc);
      if (acc) k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 2", k);
    end
    for (int i = 0; i < 10 && k < 3; i++) begin
      cycle(1'b1, ds[k], os[k], '0, '0, 1'b1, acc);
      if (acc) k++;
    end
    flush();
  endtask

  task automatic test_random_bp();
    logic         pend = 1'b0;
    logic [W-1:0] d = '0, p = '0, c = '0;
    logic [3:0]   op = '0;
    logic         acc;
    lat_chk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        d  = W'($urandom);
        op = 4'($urandom_range(0, 15));
        p  = W'($urandom);
        c  = W'($urandom);
      end
      cycle(pend, d, op, p, c, ($urandom_range(0, 2) != 0), acc);
      if (acc) pend = 1'b0;
    end
    flush();
  endtask

  task automatic test_illegal();
    logic acc;
    lat_chk = 1'b1;
    cycle(1'b1, 8'h5A, 4'd14, '0, '0, 1'b1, acc);
    for (int op = 10; op < 16; op++)
      cycle(1'b1, W'($urandom), 4'(op), W'($urandom), W'($urandom), 1'b1, acc);
    flush();
  endtask

  task automatic test_wildeq();
    logic acc;
    lat_chk = 1'b1;
    cycle(1'b1, 8'h0A, 4'd10, 8'h02, 8'h03, 1'b1, acc);
    cycle(1'b1, 8'h0A, 4'd11, 8'h02, 8'h03, 1'b1, acc);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, W'($urandom), 4'($urandom_range(10, 11)), W'($urandom),
            W'($urandom_range(0, 3)) << $urandom_range(0, 6), 1'b1, acc);
    flush();
  endtask

  task automatic test_midreset();
    logic acc;
    lat_chk = 1'b0;
    cycle(1'b1, W'($urandom), 4'd0, '0, '0, 1'b0, acc);
    cycle(1'b1, W'($urandom), 4'd1, '0, '0, 1'b0, acc);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_err, out_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b e=%b d=%h expected all 0", out_valid, out_err, out_data);
    end
    checks++;
    if ((op_count !== '0) || (sat_count !== '0)) begin
      errors++;
      $display("FAIL midreset_count: got %0d/%0d expected 0/0", op_count, sat_count);
    end
    q.delete();
    exp_cnt    = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 4'd0, '0, '0, 1'b1, acc);
    lat_chk = 1'b1;
    cycle(1'b1, 8'h3C, 4'd2, '0, '0, 1'b1, acc);
    flush();
  endtask

  task automatic test_saturate();
    logic acc;
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, W'($urandom), 4'($urandom_range(0, 9)), '0, '0, 1'b1, acc);
    flush();
    checks++;
    if (sat_count !== 2'd3) begin
      errors++;
      $display("FAIL saturate: got %0d expected 3", sat_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_random_bp();
    test_illegal();
`ifdef UNARY_OPS_PIPE_WILDEQ_EN
    test_wildeq();
`endif
    test_midreset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unary_ops_pipe.md
Name: unary_ops_pipe

Overview:
- Parametrised, pipelined successor of the unary-operator test block.
- Applies a run-time-selected unary operator to a WIDTH-bit operand and returns the result through a 2-stage valid/ready pipeline.
- Keeps a saturating count of completed operations.
- Used as the sequential systest vehicle for unary/reduction operator translation under backpressure.

Parameters:
- WIDTH, 8, operand/result width; legal 1..64.
- CNT_W, 16, width of the completed-operation counter; legal 1..32.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset; deassertion synchronous to clk externally.
- in_valid  input  1  operand/op offered.
- in_ready  output  1  block accepts this cycle.
- in_data  input  WIDTH  operand.
- in_op  input  4  operator code.
- in_pat  input  WIDTH  wildcard pattern (used only with the optional feature).
- in_care  input  WIDTH  wildcard care mask, 1 = compare bit (optional feature only).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  result.
- out_err  output  1  illegal opcode flag, aligned with out_data.
- op_count  output  CNT_W  completed-output count, saturating.

Behaviour:
- Reset (async, reset_n=0): stage valids=0, out_valid=0, out_data=0, out_err=0, op_count=0. in_ready=1 immediately after reset. Reset mid-operation discards all in-flight items; no partial output.
- Handshake: a transfer occurs when valid&&ready, on both sides.
- S1 (operand/op register): loads on in_valid&&in_ready. in_ready = !s1_valid || adv1, where adv1 = !out_valid || out_ready. Combinational path out_ready -> in_ready is allowed.
- S2 (result register): computes from S1 when adv1 && s1_valid. out_valid=1 for that result.
- Latency: exactly 2 cycles from accept to out_valid with no stall. Full throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, out_data, out_err and out_valid hold stable and S1 holds. Maximum 2 items in flight.
- Simultaneous accept and drain in the same cycle: both occur, no bubble.
- Opcodes (d = S1 operand):
  - 0 ~d
  - 1 +d (identity)
  - 2 -d, two's complement mod 2^WIDTH
  - 3 !d
  - 4 &d
  - 5 ~&d
  - 6 |d
  - 7 ~|d
  - 8 ^d
  - 9 ~^d
  - 10/11 wildcard eq/neq (optional feature)
- 1-bit results (ops 3–11) are zero-extended into out_data[0].
- Illegal opcode (12–15, or 10/11 when feature off): out_data=0, out_err=1. The item still flows through the pipeline and is counted.
- WIDTH=1: reductions equal the bit itself (or its inverse for the negated forms). -d equals d.
- op_count increments on each out_valid&&out_ready and saturates at 2^CNT_W-1 (no wrap).

Optional Feature:
- Macro: UNARY_OPS_PIPE_WILDEQ_EN.
- Defined:
  - op 10: out_data[0] = &(~(d ^ in_pat) | ~in_care).
  - op 11: the inverse of op 10.
  - in_pat and in_care are registered in S1 with the operand.
- Undefined:
  - in_pat and in_care are ignored and no S1 storage exists for them.
  - ops 10/11 take the illegal-opcode behaviour.

Test Plan:
- Reset then WIDTH=8 stream with out_ready=1: d=8'h00 op0,1,2,3 -> 8'hFF, 8'h00, 8'h00, 8'h01, each out_valid exactly 2 cycles after its accept; op_count=4.
- d=8'h80 op2 -> 8'h80; d=8'hFF op4 -> 1, op5 -> 0; d=8'h07 op8 -> 1, op9 -> 0; d=8'h00 op6 -> 0, op7 -> 1.
- Backpressure: 3 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts; out_data holds first result; release -> 3 results in order, no loss or duplication.
- Illegal op 14 on d=8'h5A -> out_data=0, out_err=1, op_count increments. With feature on: d=4'b1010, pat=4'b0010, care=4'b0011, op10 -> 1, op11 -> 0 (WIDTH=4).
- reset_n pulsed low while 2 items in flight -> out_valid=0 asynchronously, op_count=0, no stale output after release. CNT_W=2: 5 outputs -> op_count=3.
